// File: rtl/systolic_array_feeder_if.sv
// Load port and array-edge feed bundle for the systolic array feeder.
// master: load/start driver (upstream). slave: the feeder itself.
// Signals: load_valid/ready/sel/addr/data, start, sa_start, A_in, B_in,
//          feed_valid, busy, done.
interface systolic_array_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 2
);
  localparam int AW = (N * N > 1) ? $clog2(N * N) : 1;

  logic                    load_valid;
  logic                    load_ready;
  logic                    load_sel;
  logic [AW-1:0]           load_addr;
  logic [DATA_WIDTH-1:0]   load_data;
  logic                    start;
  logic                    sa_start;
  logic [N*DATA_WIDTH-1:0] A_in;
  logic [N*DATA_WIDTH-1:0] B_in;
  logic                    feed_valid;
  logic                    busy;
  logic                    done;

  modport master (
    output load_valid, load_sel, load_addr, load_data, start,
    input  load_ready, sa_start, A_in, B_in, feed_valid, busy, done
  );

  modport slave (
    input  load_valid, load_sel, load_addr, load_data, start,
    output load_ready, sa_start, A_in, B_in, feed_valid, busy, done
  );
endinterface

// File: rtl/systolic_array_feeder.sv
// Purpose: buffers N x N A and B operands and streams them, diagonally skewed, into a systolic array.
// Latency: beat 0 appears one cycle after the start edge; done 2N-1+DRAIN_CYCLES+1 cycles after it.
// Backpressure: load_ready is high only in IDLE; load requests outside IDLE are dropped, not held.
// Ports: clk, rst (async, active-high); bus (slave modport): load_valid/ready/sel/addr/data,
//        start, sa_start, A_in (left edge lanes), B_in (top edge lanes), feed_valid, busy, done.
module systolic_array_feeder #(
  parameter int DATA_WIDTH   = 8,
  parameter int N            = 2,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  systolic_array_feeder_if.slave bus
);

  localparam int NN        = N * N;
  localparam int FEED_LAST = 2 * N - 2;
  localparam int CNT_MAX   = (FEED_LAST > DRAIN_CYCLES) ? FEED_LAST : DRAIN_CYCLES;
  localparam int CW        = $clog2(CNT_MAX + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           t_q, t_d;
  logic [DATA_WIDTH-1:0]   a_q [NN];
  logic [DATA_WIDTH-1:0]   a_d [NN];
  logic [DATA_WIDTH-1:0]   b_q [NN];
  logic [DATA_WIDTH-1:0]   b_d [NN];
  logic [N*DATA_WIDTH-1:0] a_in_q, a_in_d;
  logic [N*DATA_WIDTH-1:0] b_in_q, b_in_d;
  logic                    feed_valid_q, feed_valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    sa_start_q, sa_start_d;
  logic                    load_ready_q, load_ready_d;
  logic [31:0]             wr_idx;
  logic                    wr_en;

  always_comb begin
    state_d      = state_q;
    t_d          = t_q;
    a_d          = a_q;
    b_d          = b_q;
    a_in_d       = '0;
    b_in_d       = '0;
    wr_idx       = 32'(bus.load_addr);
    // load_ready_q is high exactly when we sit in IDLE, so it gates writes.
    wr_en        = bus.load_valid && load_ready_q && (wr_idx < 32'(NN));

    if (wr_en) begin
      if (bus.load_sel) b_d[bus.load_addr] = bus.load_data;
      else              a_d[bus.load_addr] = bus.load_data;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FEED;
          t_d     = '0;
        end
      end
      S_FEED: begin
        if (t_q == CW'(FEED_LAST)) begin
          t_d     = '0;
          state_d = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
        end else begin
          t_d = t_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (t_q == CW'(DRAIN_CYCLES - 1)) begin
          t_d     = '0;
          state_d = S_DONE;
        end else begin
          t_d = t_q + CW'(1);
        end
      end
      S_DONE: begin
        t_d     = '0;
        state_d = S_IDLE;
      end
      default: begin
        t_d     = '0;
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so beat t is visible the
    // cycle after the edge that enters it. Using a_d/b_d lets a write that
    // lands on the start edge show up in beat 0.
    feed_valid_d = (state_d == S_FEED);
    busy_d       = (state_d == S_FEED) || (state_d == S_DRAIN);
    done_d       = (state_d == S_DONE);
    sa_start_d   = (state_q == S_IDLE) && (state_d == S_FEED);
    load_ready_d = (state_d == S_IDLE);

    // Lane i carries element (i, c) on beat t = i + c: row skew on A,
    // column skew on B.
    if (state_d == S_FEED) begin
      for (int i = 0; i < N; i++) begin
        for (int c = 0; c < N; c++) begin
          if (t_d == CW'(i + c)) begin
            a_in_d[i*DATA_WIDTH +: DATA_WIDTH] = a_d[i*N + c];
            b_in_d[i*DATA_WIDTH +: DATA_WIDTH] = b_d[c*N + i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      t_q          <= '0;
      for (int e = 0; e < NN; e++) begin
        a_q[e] <= '0;
        b_q[e] <= '0;
      end
      a_in_q       <= '0;
      b_in_q       <= '0;
      feed_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sa_start_q   <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      t_q          <= t_d;
      a_q          <= a_d;
      b_q          <= b_d;
      a_in_q       <= a_in_d;
      b_in_q       <= b_in_d;
      feed_valid_q <= feed_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      sa_start_q   <= sa_start_d;
      load_ready_q <= load_ready_d;
    end
  end

  assign bus.A_in       = a_in_q;
  assign bus.B_in       = b_in_q;
  assign bus.feed_valid = feed_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.sa_start   = sa_start_q;
  assign bus.load_ready = load_ready_q;

endmodule

// File: doc/systolic_array_feeder.md
Name: systolic_array_feeder

Overview:
- Upstream stage of the covariance-unit systolic array.
- Buffers one N×N A operand and one N×N B operand, written element by element over a valid/ready load port.
- On start, streams them into the array's left edge (A_in) and top edge (B_in) with the diagonal skew an output-stationary array needs. Then drives zeros for a drain window and pulses done.
- The array start pulse (sa_start) is generated here, aligned with the first beat.

Parameters:
- DATA_WIDTH, 8, element width in bits.
- N, 2, array dimension. Lane count on A_in/B_in. The load address covers N*N entries.
- DRAIN_CYCLES, 2, zero beats after the last data beat before done.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- load_valid  in  1  load request.
- load_ready  out  1  load accepted when high with load_valid.
- load_sel  in  1  0 = write A buffer, 1 = write B buffer.
- load_addr  in  clog2(N*N)  row-major index (row*N+col).
- load_data  in  DATA_WIDTH  element value.
- start  in  1  begin a feed sequence.
- sa_start  out  1  one-cycle start to the systolic array.
- A_in  out  N*DATA_WIDTH  left-edge lanes; lane i at bits [i*DW +: DW].
- B_in  out  N*DATA_WIDTH  top-edge lanes; lane j at bits [j*DW +: DW].
- feed_valid  out  1  high on data beats.
- busy  out  1  high in FEED and DRAIN.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, any time, including mid-sequence):
  - State goes to IDLE; beat counter goes to 0.
  - Both buffers are cleared to 0.
  - All outputs go to 0 except load_ready, which is 1.
- All outputs are registered.
- States: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - load_ready = 1.
  - A write occurs on a rising edge with load_valid & load_ready.
  - start sampled high goes to FEED, beat t = 0.
- Start/write in the same cycle: the write commits at the same edge, and the feed uses the new value.
- FEED (2N-1 cycles, t = 0..2N-2):
  - A lane i = A[i][t-i] if 0 <= t-i < N, else 0.
  - B lane j = B[t-j][j] if 0 <= t-j < N, else 0.
  - feed_valid = 1; busy = 1; load_ready = 0.
  - sa_start = 1 only in the first FEED cycle (t = 0).
  - After t = 2N-2, go to DRAIN.
- DRAIN (DRAIN_CYCLES cycles):
  - A_in = B_in = 0; feed_valid = 0; busy = 1; load_ready = 0.
  - DRAIN_CYCLES = 0 goes straight to DONE.
- DONE (1 cycle):
  - done = 1; busy = 0; load_ready = 0.
  - Next state is IDLE.
- Latency: for the start edge E, beat 0 is visible in the cycle after E. done is high in cycle 2N-1+DRAIN_CYCLES+1 after E (N=2, DRAIN=2: cycle 6).
- start is ignored outside IDLE. No queuing.
- load_valid is ignored while load_ready = 0. No write happens, and the request is not held.
- Buffers persist across sequences. A second start with no new loads replays identical beats.
- An out-of-range load_addr (>= N*N, only when N*N is not a power of two) is dropped silently.
- Values pass through unchanged. There is no arithmetic or width change.

Test Plan:
1. Reset behaviour: assert rst mid-FEED.
   - Required: A_in, B_in, feed_valid, busy, done and sa_start go to 0 immediately, without waiting for a clock edge.
   - Required: load_ready goes to 1.
   - Required: a later start with no loads feeds all-zero beats.
2. Basic feed: load A = [[1,2],[3,4]], B = [[5,6],[7,8]], then start. Required beats:
   - t0: A_in = 16'h0001, B_in = 16'h0005, sa_start = 1.
   - t1: A_in = 16'h0302, B_in = 16'h0607.
   - t2: A_in = 16'h0400, B_in = 16'h0800.
   - Then 2 zero cycles, done in cycle 6 after the start edge, then IDLE.
3. Handshake: hold load_valid with load_addr = 0, data = 8'hFF during FEED.
   - Required: load_ready = 0 and the buffer is unchanged.
   - Required: when the sequence is restarted, t0 still shows A_in = 16'h0001.
4. Start ignored: pulse start during DRAIN.
   - Required: no second sequence; exactly one done pulse.
5. Simultaneous events: in IDLE, write A[0][0] = 9 and assert start in the same cycle.
   - Required: t0 A_in = 16'h0009.
6. Back-to-back: assert start in the cycle right after done.
   - Required: second sequence replays the beats of scenario 2 identically.
